// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } pll_seq_state_e;

  // Saturating increment so the event counter never wraps.
  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
module pll_seq_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer driving the active-low system reset.
// Define PLL_SEQ_TIMEOUT_EN to retry the PLL when lock does not arrive in time.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_W               = 17
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic                hresetn,
  output logic                ready,
  output logic [STATE_W-1:0]  state,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int unsigned MaxPS = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                  RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MaxCycles = (MaxPS > LOCK_TIMEOUT_CYCLES) ? MaxPS : LOCK_TIMEOUT_CYCLES;

  if (RST_PULSE_CYCLES == 0 || LOCK_STABLE_CYCLES == 0 ||
      (64'(MaxCycles) - 64'd1) >= (64'd1 << CNT_W)) begin : g_param_check
    $error("pll_reset_sequencer: cycle counts must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] PulseLast  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  pll_seq_state_e      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_rst_q;
  logic                hresetn_q;
  logic                lock_s;

  pll_seq_sync2 u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PulseLast) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock arriving in the timeout cycle takes priority over the retry.
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
`ifdef PLL_SEQ_TIMEOUT_EN
        end else if (cnt_q == TimeoutLast) begin
          state_d  = S_PLL_RST;
          cnt_d    = '0;
          relock_d = sat_inc(relock_q);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        // A glitch restarts the stability window without counting as a relock.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d  = S_PLL_RST;
          cnt_d    = '0;
          relock_d = sat_inc(relock_q);
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      hresetn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      pll_rst_q <= (state_d == S_PLL_RST);
      hresetn_q <= (state_q == S_RUN);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign hresetn    = hresetn_q;
  assign ready      = hresetn_q;
  assign state      = state_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues timed output changes, a negedge monitor checks them.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  logic       refclk     = 1'b0;
  logic       rst        = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       hresetn;
  logic       ready;
  logic [1:0] state;
  logic [7:0] relock_cnt;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .CNT_W               (17)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .hresetn    (hresetn),
    .ready      (ready),
    .state      (state),
    .relock_cnt (relock_cnt)
  );

  typedef logic [12:0] snap_t;
  typedef struct {
    int    c;
    snap_t s;
  } ev_t;

  ev_t   exp_q[$];
  int    cyc      = 0;
  int    n_checks = 0;
  int    n_pass   = 0;
  snap_t prev_snap = {2'b00, 1'b1, 1'b0, 1'b0, 8'h00};
  snap_t cur_snap;
  ev_t   cur_ev;
  logic [7:0] rc_model;

  always @(posedge refclk) cyc <= cyc + 1;

  function automatic snap_t mk(input logic [1:0] st, input logic pr, input logic hr,
                               input logic [7:0] rc);
    return {st, pr, hr, hr, rc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic expect_ev(input int c, input snap_t s);
    ev_t e;
    e.c = c;
    e.s = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed output change must match the next queued event.
  always @(negedge refclk) begin
    cur_snap = {state, pll_rst, hresetn, ready, relock_cnt};
    if (cur_snap !== prev_snap) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_change: actual %h required no change (cycle %0d)",
                 cur_snap, cyc);
      end else begin
        cur_ev = exp_q.pop_front();
        chk("event_cycle", cyc, cur_ev.c);
        chk("event_outputs", 32'(cur_snap), 32'(cur_ev.s));
      end
      prev_snap = cur_snap;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic release_rst(output int r);
    @(negedge refclk);
    rst = 1'b0;
    r   = cyc;
  endtask

  // Asynchronous reset mid-operation; outputs must react before the next edge.
  task automatic assert_rst();
    @(posedge refclk);
    #2;
    rst        = 1'b1;
    pll_locked = 1'b0;
    expect_ev(cyc, mk(S_PLL_RST, 1'b1, 1'b0, 8'd0));
    #1;
    chk("async_pll_rst", 32'(pll_rst), 32'd1);
    chk("async_hresetn", 32'(hresetn), 32'd0);
    chk("async_relock_cnt", 32'(relock_cnt), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    wait_neg(2);
  endtask

  // Release reset; lock arrives 3 cycles after pll_rst falls, optionally glitching once.
  task automatic bringup(input bit glitch);
    int r;
    release_rst(r);
    expect_ev(r + 4, mk(S_WAIT_LOCK, 1'b0, 1'b0, 8'd0));
    expect_ev(r + 9, mk(S_STABLE, 1'b0, 1'b0, 8'd0));
    if (glitch) begin
      expect_ev(r + 13, mk(S_WAIT_LOCK, 1'b0, 1'b0, 8'd0));
      expect_ev(r + 14, mk(S_STABLE, 1'b0, 1'b0, 8'd0));
      expect_ev(r + 22, mk(S_RUN, 1'b0, 1'b0, 8'd0));
      expect_ev(r + 23, mk(S_RUN, 1'b0, 1'b1, 8'd0));
    end else begin
      expect_ev(r + 17, mk(S_RUN, 1'b0, 1'b0, 8'd0));
      expect_ev(r + 18, mk(S_RUN, 1'b0, 1'b1, 8'd0));
    end
    wait_neg(6);
    pll_locked = 1'b1;
    if (glitch) begin
      wait_neg(4);
      pll_locked = 1'b0;
      wait_neg(1);
      pll_locked = 1'b1;
      wait_neg(9);
      chk("glitch_hresetn_low", 32'(hresetn), 32'd0);
      wait_neg(3);
    end else begin
      wait_neg(12);
    end
  endtask

  // Lock loss from S_RUN, followed by relock 3 cycles after pll_rst falls.
  task automatic lose_lock(inout logic [7:0] rc);
    int m;
    logic [7:0] rn;
    m  = cyc;
    rn = (rc == 8'hff) ? rc : rc + 8'd1;
    expect_ev(m + 3,  mk(S_PLL_RST, 1'b1, 1'b1, rn));
    expect_ev(m + 4,  mk(S_PLL_RST, 1'b1, 1'b0, rn));
    expect_ev(m + 7,  mk(S_WAIT_LOCK, 1'b0, 1'b0, rn));
    expect_ev(m + 12, mk(S_STABLE, 1'b0, 1'b0, rn));
    expect_ev(m + 20, mk(S_RUN, 1'b0, 1'b0, rn));
    expect_ev(m + 21, mk(S_RUN, 1'b0, 1'b1, rn));
    pll_locked = 1'b0;
    wait_neg(9);
    pll_locked = 1'b1;
    wait_neg(12);
    rc = rn;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    #1 rst = 1'b1;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pll_rst", 32'(pll_rst), 32'd1);
    chk("reset_hresetn", 32'(hresetn), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_relock_cnt", 32'(relock_cnt), 32'd0);

    bringup(1'b0);
    rc_model = 8'd0;
    lose_lock(rc_model);
    chk("relock_after_loss", 32'(relock_cnt), 32'd1);

    assert_rst();
    bringup(1'b1);

    assert_rst();
    release_rst(r);
    expect_ev(r + 4, mk(S_WAIT_LOCK, 1'b0, 1'b0, 8'd0));
`ifdef PLL_SEQ_TIMEOUT_EN
    expect_ev(r + 36, mk(S_PLL_RST, 1'b1, 1'b0, 8'd1));
    expect_ev(r + 40, mk(S_WAIT_LOCK, 1'b0, 1'b0, 8'd1));
    expect_ev(r + 72, mk(S_PLL_RST, 1'b1, 1'b0, 8'd2));
    expect_ev(r + 76, mk(S_WAIT_LOCK, 1'b0, 1'b0, 8'd2));
    wait_neg(80);
    chk("timeout_relock_cnt", 32'(relock_cnt), 32'd2);
`else
    wait_neg(80);
    chk("no_timeout_state", 32'(state), 32'(S_WAIT_LOCK));
    chk("no_timeout_relock_cnt", 32'(relock_cnt), 32'd0);
`endif

    assert_rst();
    bringup(1'b0);
    rc_model = 8'd0;
    for (int i = 0; i < 300; i++) lose_lock(rc_model);
    chk("saturated_relock_cnt", 32'(relock_cnt), 32'd255);

    wait_neg(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
